survivor_shift_mem: RTL and testbench

- Parametrised survivor-path decision memory for the pipelined Viterbi decoder.
- Accepts per-lane decision bits, each tagged with a row address, from the ACS stage. Shifts them into per-lane, per-row shift registers.
- Presents one lane's full history window at a time to the traceback stage through a valid/ready handshake, with a fill tracker and a flush control.
- Sits between the ACS/bus-routing stage and the traceback/output-select stage.

---
 rtl/survivor_shift_mem_pkg.sv | 27 ++
 rtl/survivor_shift_mem_if.sv | 33 +++
 rtl/survivor_shift_mem_lane.sv | 48 ++++
 rtl/survivor_shift_mem.sv | 72 +++++++
 tb/tb_survivor_shift_mem.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/survivor_shift_mem_pkg.sv
// Shared defaults and index helpers for the survivor decision memory.
// Pair and out_data bit layouts are defined once here.
package survivor_mem_pkg;

    localparam int DEF_NUM_LANES = 8;
    localparam int DEF_SLOTS     = 4;
    localparam int DEF_DEPTH     = 8;

    // Flat index of (lane, slot) in in_dec / in_addr
    function automatic int pair_idx(input int l, input int s, input int slots);
        return l * slots + s;
    endfunction

    // Flat index of (row, age) in a lane history word
    function automatic int hist_bit(input int r, input int k, input int depth);
        return r * depth + k;
    endfunction

    function automatic int addr_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic int lane_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/survivor_shift_mem_if.sv
// ACS-side decision bus and traceback-side readout handshake.
// master drives decisions and out_ready; slave is the memory.
interface survivor_shift_mem_if
    import survivor_mem_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SLOTS     = DEF_SLOTS,
    parameter int DEPTH     = DEF_DEPTH
);

    localparam int ADDR_W = addr_width(SLOTS);
    localparam int LANE_W = lane_width(NUM_LANES);

    logic                              in_valid;
    logic [NUM_LANES*SLOTS-1:0]        in_dec;
    logic [NUM_LANES*SLOTS*ADDR_W-1:0] in_addr;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANE_W-1:0]                 out_lane;
    logic [SLOTS*DEPTH-1:0]            out_data;
    logic                              out_wrap;

    modport master (
        output in_valid, in_dec, in_addr, out_ready,
        input  out_valid, out_lane, out_data, out_wrap
    );

    modport slave (
        input  in_valid, in_dec, in_addr, out_ready,
        output out_valid, out_lane, out_data, out_wrap
    );

endinterface

// File: rtl/survivor_shift_mem_lane.sv
// One lane: priority row decode of the slot pairs and SLOTS shift rows.
// Row r occupies hist[r*DEPTH +: DEPTH], bit 0 being the newest decision.
module survivor_lane
    import survivor_mem_pkg::*;
#(
    parameter int SLOTS  = DEF_SLOTS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(DEF_SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [SLOTS-1:0]        dec,
    input  logic [SLOTS*ADDR_W-1:0] addr,
    output logic [SLOTS*DEPTH-1:0]  hist
);

    logic [SLOTS-1:0]            next_bit;
    logic [SLOTS-1:0][DEPTH-1:0] rows;

    // Ascending slot scan: a later (higher) slot overrides earlier hits
    always_comb begin
        next_bit = '0;
        for (int s = 0; s < SLOTS; s++) begin
            for (int r = 0; r < SLOTS; r++) begin
                if (addr[s*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    next_bit[r] = dec[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rows <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < SLOTS; r++) begin
                rows[r] <= {rows[r][DEPTH-2:0], next_bit[r]};
            end
        end
    end

    for (genvar r = 0; r < SLOTS; r++) begin : g_row
        assign hist[hist_bit(r, 0, DEPTH) +: DEPTH] = rows[r];
    end

endmodule

// File: rtl/survivor_shift_mem.sv
// Survivor decision memory: per-lane shift rows, fill tracking and a
// round-robin lane readout towards the traceback stage.
module survivor_shift_mem
    import survivor_mem_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SLOTS     = DEF_SLOTS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    survivor_shift_mem_if.slave  bus
);

    localparam int ADDR_W = addr_width(SLOTS);
    localparam int LANE_W = lane_width(NUM_LANES);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HIST_W = SLOTS * DEPTH;

    logic [NUM_LANES-1:0][HIST_W-1:0] hist;
    logic [CNT_W-1:0]                 fill_cnt;
    logic [LANE_W-1:0]                lane_ptr;
    logic                             full;
    logic                             accept;
    logic                             last_lane;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        localparam int P0 = pair_idx(l, 0, SLOTS);

        survivor_lane #(
            .SLOTS  (SLOTS),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (bus.in_valid),
            .dec      (bus.in_dec[P0 +: SLOTS]),
            .addr     (bus.in_addr[P0*ADDR_W +: SLOTS*ADDR_W]),
            .hist     (hist[l])
        );
    end

    assign full      = (fill_cnt == CNT_W'(DEPTH));
    assign accept    = full && bus.out_ready;
    assign last_lane = (lane_ptr == LANE_W'(NUM_LANES - 1));

    // Fill saturates: once a full window exists it stays full
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            fill_cnt <= '0;
        end else if (bus.in_valid && !full) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lane_ptr <= '0;
        end else if (accept) begin
            lane_ptr <= last_lane ? '0 : lane_ptr + 1'b1;
        end
    end

    assign bus.out_valid = full;
    assign bus.out_lane  = lane_ptr;
    assign bus.out_data  = hist[lane_ptr];
    assign bus.out_wrap  = accept && last_lane;

endmodule

// File: tb/tb_survivor_shift_mem.sv
// Randomised and directed bench for survivor_shift_mem against a
// behavioural history model, plus a small second-parameter instance.
module tb_survivor_shift_mem;

    localparam int NL = 8;
    localparam int SL = 4;
    localparam int D  = 8;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic flush2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    survivor_shift_mem_if #(.NUM_LANES(NL), .SLOTS(SL), .DEPTH(D)) bus ();
    survivor_shift_mem_if #(.NUM_LANES(4), .SLOTS(2), .DEPTH(16)) bus2 ();

    survivor_shift_mem #(.NUM_LANES(NL), .SLOTS(SL), .DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    survivor_shift_mem #(.NUM_LANES(4), .SLOTS(2), .DEPTH(16)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush2),
        .bus   (bus2)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs as seen by the DUT at each rising edge
    logic              cap_rst = 1'b1;
    logic              cap_flush = 1'b0;
    logic              cap_valid = 1'b0;
    logic              cap_ready = 1'b0;
    logic [NL*SL-1:0]  cap_dec = '0;
    logic [NL*SL*AW-1:0] cap_addr = '0;

    always @(posedge clk) begin
        cap_rst   <= rst;
        cap_flush <= flush;
        cap_valid <= bus.in_valid;
        cap_ready <= bus.out_ready;
        cap_dec   <= bus.in_dec;
        cap_addr  <= bus.in_addr;
    end

    // mh[l][r][k]: lane l, row r, age k (0 newest)
    bit mh [NL][SL][D];
    int m_fill = 0;
    int m_ptr  = 0;

    always @(negedge clk) begin
        logic [SL*D-1:0] exp_data;
        bit acc;
        bit nb;
        bit found;
        if (cap_rst || cap_flush) begin
            foreach (mh[l, r, k]) mh[l][r][k] = 1'b0;
            m_fill = 0;
            m_ptr  = 0;
        end else begin
            acc = (m_fill == D) && cap_ready;
            if (cap_valid) begin
                for (int l = 0; l < NL; l++) begin
                    for (int r = 0; r < SL; r++) begin
                        nb = 1'b0;
                        found = 1'b0;
                        for (int s = SL - 1; s >= 0; s--) begin
                            if (!found && cap_addr[(l*SL+s)*AW +: AW] == r) begin
                                nb = cap_dec[l*SL+s];
                                found = 1'b1;
                            end
                        end
                        for (int k = D - 1; k > 0; k--) mh[l][r][k] = mh[l][r][k-1];
                        mh[l][r][0] = nb;
                    end
                end
                if (m_fill < D) m_fill++;
            end
            if (acc) m_ptr = (m_ptr + 1) % NL;
        end
        exp_data = '0;
        for (int r = 0; r < SL; r++)
            for (int k = 0; k < D; k++)
                exp_data[r*D+k] = mh[m_ptr][r][k];
        check("m_out_valid", bus.out_valid, (m_fill == D));
        check("m_out_lane", bus.out_lane, m_ptr);
        check("m_out_data", bus.out_data, exp_data);
        check("m_out_wrap", bus.out_wrap,
              (m_fill == D) && bus.out_ready && (m_ptr == NL - 1));
    end

    task automatic rand_bus();
        bus.in_dec  = $urandom;
        bus.in_addr = {$urandom, $urandom};
    endtask

    initial begin
        int lane_exp;
        int wraps;

        rst = 1'b1;
        flush = 1'b0;
        flush2 = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        rand_bus();
        bus2.in_valid = 1'b0;
        bus2.in_dec = '0;
        bus2.in_addr = '0;
        bus2.out_ready = 1'b0;

        // Reset with in_valid active
        tick();
        rand_bus();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_lane", bus.out_lane, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_wrap", bus.out_wrap, 0);
        rst = 1'b0;

        // Fill and latency on lane 0
        rand_bus();
        bus.in_dec[3:0] = 4'hf;
        bus.in_addr[7:0] = 8'he4;
        tick();
        for (int i = 0; i < 6; i++) begin
            rand_bus();
            bus.in_dec[3:0] = 4'h0;
            bus.in_addr[7:0] = 8'he4;
            tick();
        end
        check("fill7_valid", bus.out_valid, 0);
        rand_bus();
        bus.in_dec[3:0] = 4'h0;
        bus.in_addr[7:0] = 8'he4;
        tick();
        check("fill8_valid", bus.out_valid, 1);
        check("fill8_lane", bus.out_lane, 0);
        check("fill8_data", bus.out_data, 32'h8080_8080);
        rand_bus();
        bus.in_dec[3:0] = 4'h0;
        bus.in_addr[7:0] = 8'he4;
        tick();
        check("fill9_data", bus.out_data, 0);

        // Collision on lane 2: all slots target row 1
        rand_bus();
        bus.in_dec[11:8] = 4'b0101;
        bus.in_addr[23:16] = 8'h55;
        tick();
        rand_bus();
        bus.in_dec[11:8] = 4'b1000;
        bus.in_addr[23:16] = 8'h55;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        #1;
        check("coll_lane", bus.out_lane, 2);
        check("coll_data", bus.out_data & 32'h0303_0303, 32'h0000_0100);

        // Readout sweep through all lanes
        bus.out_ready = 1'b1;
        wraps = 0;
        for (int i = 0; i < NL; i++) begin
            lane_exp = (2 + i) % NL;
            #1;
            check("sweep_lane", bus.out_lane, lane_exp);
            check("sweep_wrap", bus.out_wrap, (lane_exp == NL - 1));
            if (bus.out_wrap) wraps++;
            tick();
        end
        check("sweep_wraps", wraps, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_lane", bus.out_lane, 2);
        end

        // Flush mid-operation with in_valid high
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_bus();
            tick();
        end
        flush = 1'b1;
        rand_bus();
        tick();
        flush = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_lane", bus.out_lane, 0);
        check("flush_data", bus.out_data, 0);
        for (int i = 0; i < 7; i++) begin
            rand_bus();
            tick();
        end
        check("reflush7_valid", bus.out_valid, 0);
        rand_bus();
        tick();
        check("reflush8_valid", bus.out_valid, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 99) == 0);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.out_ready = $urandom_range(0, 1);
            rand_bus();
            tick();
        end
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;

        // Second parameter set: 4 lanes, 2 slots, depth 16
        bus2.in_valid = 1'b1;
        bus2.in_dec = 8'h03;
        bus2.in_addr = 8'h02;
        tick();
        bus2.in_dec = '0;
        for (int i = 0; i < 14; i++) tick();
        check("p2_fill15_valid", bus2.out_valid, 0);
        tick();
        check("p2_fill16_valid", bus2.out_valid, 1);
        check("p2_fill16_data", bus2.out_data, 32'h8000_8000);
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("p2_lane", bus2.out_lane, i);
            check("p2_wrap", bus2.out_wrap, (i == 3));
            tick();
        end
        bus2.out_ready = 1'b0;
        #1;
        check("p2_lane_back", bus2.out_lane, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
